// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES request arbiter and its helpers.
package aes_arb_pkg;

   // Arbiter job sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // The engine only has three key slots; this encoding selects none of them.
   localparam logic [1:0] KSEL_ILLEGAL = 2'b11;

   // Default number of cycles to wait for the engine before giving up.
   localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// Round-robin priority picker with a registered rotating pointer.
// The pointer moves past the winner only when update_i is high, so the
// caller decides when a pick really counts as a grant.
module rr_arbiter #(
   parameter int N    = 2,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_i,
   input  logic            update_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] gnt_id_o,
   output logic            gnt_valid_o
);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;

   // Scan from the pointer upward, wrapping once, and take the first request seen.
   always_comb begin
      int idx;
      idx         = 0;
      gnt_o       = '0;
      gnt_id_o    = '0;
      gnt_valid_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!gnt_valid_o && req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_o[idx]  = 1'b1;
            gnt_id_o    = ID_W'(idx);
         end
      end
   end

   // Next pointer sits just past the winner so it gets lowest priority next time.
   always_comb begin
      ptr_d = ptr_q;
      if (update_i && gnt_valid_o) begin
         if (gnt_id_o == ID_W'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_id_o + ID_W'(1);
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES engine between several requesters. One job is in flight at a
// time: grant, pulse start, wait for the engine (with a timeout), then hold the
// tagged result until the consumer accepts it.
module aes_req_arbiter
   import aes_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 debug_mode_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   output logic [N_REQ-1:0]     req_ready_o,
   input  logic [N_REQ*128-1:0] req_data_i,
   input  logic [N_REQ*2-1:0]   req_ksel_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [127:0]         rsp_data_o,
   output logic [ID_W-1:0]      rsp_id_o,
   output logic                 rsp_err_o,
   output logic                 aes_start_o,
   output logic [127:0]         aes_data_o,
   output logic [1:0]           aes_ksel_o,
   input  logic [127:0]         aes_out_i,
   input  logic                 aes_out_valid_i,
   output logic                 busy_o
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [127:0]     rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic             rsp_err_q, rsp_err_d;
   logic             aes_start_q, aes_start_d;
   logic [127:0]     aes_data_q, aes_data_d;
   logic [1:0]       aes_ksel_q, aes_ksel_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]  arb_id;
   logic             arb_valid;

   logic [127:0]     req_data_arr [N_REQ];
   logic [1:0]       req_ksel_arr [N_REQ];
   logic [127:0]     sel_data;
   logic [1:0]       sel_ksel;

   // Split the flat request buses into per-requester lanes.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data_i[gi*128 +: 128];
      assign req_ksel_arr[gi] = req_ksel_i[gi*2 +: 2];
   end

   // Requests are only visible to the picker when a grant may actually happen,
   // so the picker's one-hot output doubles as the ready strobe.
   assign arb_req     = (rst_ni && state_q == IDLE && !debug_mode_i) ? req_valid_i : '0;
   assign req_ready_o = arb_gnt;
   assign sel_data    = req_data_arr[arb_id];
   assign sel_ksel    = req_ksel_arr[arb_id];

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (arb_req),
      .update_i    (arb_valid),
      .gnt_o       (arb_gnt),
      .gnt_id_o    (arb_id),
      .gnt_valid_o (arb_valid)
   );

   // Job sequencing: next state and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      aes_start_d = 1'b0;
      aes_data_d  = aes_data_q;
      aes_ksel_d  = aes_ksel_q;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               aes_data_d = sel_data;
               aes_ksel_d = sel_ksel;
               rsp_id_d   = arb_id;
               if (sel_ksel == KSEL_ILLEGAL) begin
                  // No valid key slot: answer immediately without touching the engine.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end else begin
                  state_d     = ISSUE;
                  aes_start_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // cnt_q == 0 is the first WAIT cycle, where valid may still be left over.
            if (cnt_q != '0 && aes_out_valid_i) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = aes_out_i;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset drops any job in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         aes_start_q <= 1'b0;
         aes_data_q  <= '0;
         aes_ksel_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         aes_start_q <= aes_start_d;
         aes_data_q  <= aes_data_d;
         aes_ksel_q  <= aes_ksel_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_err_o   = rsp_err_q;
   assign aes_start_o = aes_start_q;
   assign aes_data_o  = aes_data_q;
   assign aes_ksel_o  = aes_ksel_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter: two requesters, a fixed-latency
// engine model returning input XOR 1, and a round-robin reference pointer.
module tb_aes_req_arbiter;

   localparam int N    = 2;
   localparam int ID_W = 1;
   localparam int TO   = 16;
   localparam int LAT  = 10;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             debug_mode_i;
   logic [N-1:0]     req_valid_i;
   logic [N-1:0]     req_ready_o;
   logic [N*128-1:0] req_data_i;
   logic [N*2-1:0]   req_ksel_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [127:0]     rsp_data_o;
   logic [ID_W-1:0]  rsp_id_o;
   logic             rsp_err_o;
   logic             aes_start_o;
   logic [127:0]     aes_data_o;
   logic [1:0]       aes_ksel_o;
   logic [127:0]     aes_out_i;
   logic             aes_out_valid_i;
   logic             busy_o;

   aes_req_arbiter #(
      .N_REQ   (N),
      .ID_W    (ID_W),
      .TIMEOUT (TO)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .debug_mode_i    (debug_mode_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_data_i      (req_data_i),
      .req_ksel_i      (req_ksel_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_data_o      (rsp_data_o),
      .rsp_id_o        (rsp_id_o),
      .rsp_err_o       (rsp_err_o),
      .aes_start_o     (aes_start_o),
      .aes_data_o      (aes_data_o),
      .aes_ksel_o      (aes_ksel_o),
      .aes_out_i       (aes_out_i),
      .aes_out_valid_i (aes_out_valid_i),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Engine model: result = input ^ 1, valid for one cycle LAT cycles after start.
   logic         engine_en = 1'b1;
   int           eng_cnt = 0;
   logic [127:0] eng_data = '0;
   always @(posedge clk_i) begin
      if (aes_start_o) begin
         eng_cnt  <= LAT;
         eng_data <= aes_data_o ^ 128'h1;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
      end
   end
   assign aes_out_valid_i = engine_en && (eng_cnt == 1);
   assign aes_out_i       = aes_out_valid_i ? eng_data : '0;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            err;
      logic [127:0]    data;
   } exp_t;

   exp_t         exp_q[$];
   int           cyc = 0;
   int           acc_cnt[N];
   int           exp_ptr = 0;
   int           grant_cyc = 0, valid_cyc = 0, hs_cyc = 0, last_gap = 0;
   int           n_grants = 0, start_cnt = 0;
   logic         prev_rsp_valid = 1'b0;
   logic [127:0] last_data = '0;
   logic [1:0]   last_ksel = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (p + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Monitor: checks grants against the reference pointer, pushes expected
   // results at grant, pops and compares at the response handshake.
   always @(negedge clk_i) begin
      int     act;
      int     mp;
      logic [N-1:0] oh;
      exp_t   e;
      if (!rst_ni) begin
         exp_ptr        = 0;
         prev_rsp_valid = 1'b0;
      end else begin
         if (req_ready_o != '0) begin
            act = 0;
            for (int i = N - 1; i >= 0; i--) if (req_ready_o[i]) act = i;
            mp = rr_pick(req_valid_i, exp_ptr);
            oh = '0;
            if (mp >= 0) oh[mp] = 1'b1;
            chk("grant_onehot", req_ready_o, oh);
            e.id   = act[ID_W-1:0];
            e.err  = (req_ksel_i[act*2 +: 2] == 2'b11) || !engine_en;
            e.data = e.err ? '0 : (req_data_i[act*128 +: 128] ^ 128'h1);
            exp_q.push_back(e);
            last_data = req_data_i[act*128 +: 128];
            last_ksel = req_ksel_i[act*2 +: 2];
            acc_cnt[act]++;
            n_grants++;
            last_gap  = cyc - hs_cyc;
            grant_cyc = cyc;
            exp_ptr   = (act + 1) % N;
            $display("grant: req %0d data %0h ksel %0d cyc %0d", act, last_data, last_ksel, cyc);
         end
         if (aes_start_o) begin
            start_cnt++;
            chk("aes_data", aes_data_o, last_data);
            chk("aes_ksel", aes_ksel_o, last_ksel);
         end
         if (rsp_valid_o && !prev_rsp_valid) valid_cyc = cyc;
         prev_rsp_valid = rsp_valid_o;
         if (rsp_valid_o && rsp_ready_i) begin
            hs_cyc = cyc;
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_id", rsp_id_o, e.id);
               chk("rsp_err", rsp_err_o, e.err);
               chk("rsp_data", rsp_data_o, e.data);
               $display("resp: id %0d err %0d data %0h cyc %0d", rsp_id_o, rsp_err_o, rsp_data_o, cyc);
            end
         end
      end
   end

   // Requester job lists; the driver presents job acc_cnt[i] until it is accepted.
   int           nj[N];
   logic [127:0] jd[N][16];
   logic [1:0]   jk[N][16];

   task automatic add_job(input int r, input logic [127:0] d, input logic [1:0] k);
      jd[r][nj[r]] = d;
      jk[r][nj[r]] = k;
      nj[r]++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_cnt[i] < nj[i]) begin
            req_valid_i[i]          = 1'b1;
            req_data_i[i*128 +: 128] = jd[i][acc_cnt[i]];
            req_ksel_i[i*2 +: 2]     = jk[i][acc_cnt[i]];
         end else begin
            req_valid_i[i] = 1'b0;
         end
      end
   endtask

   function automatic logic all_done();
      for (int i = 0; i < N; i++) if (acc_cnt[i] != nj[i]) return 1'b0;
      return (exp_q.size() == 0) && !busy_o;
   endfunction

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      tick();
      while (n < budget && !all_done()) begin
         tick();
         n++;
      end
      chk(tag, all_done(), 1'b1);
   endtask

   task automatic wait_start(input int budget);
      int n;
      n = 0;
      while (n < budget && !aes_start_o) begin
         tick();
         n++;
      end
      chk("start_seen", aes_start_o, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, req_ready_o, '0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, '0);
      chk({tag, "_rsp_data"}, rsp_data_o, '0);
      chk({tag, "_rsp_id"}, rsp_id_o, '0);
      chk({tag, "_rsp_err"}, rsp_err_o, '0);
      chk({tag, "_start"}, aes_start_o, '0);
      chk({tag, "_aes_data"}, aes_data_o, '0);
      chk({tag, "_aes_ksel"}, aes_ksel_o, '0);
      chk({tag, "_busy"}, busy_o, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int           sc;
      int           gc;
      logic [127:0] snap_data;
      logic [2:0]   snap_ctl;

      debug_mode_i = 1'b0;
      rsp_ready_i  = 1'b1;
      req_data_i   = '0;
      req_ksel_i   = '0;
      req_valid_i  = '1;   // requests pending during reset must not be granted
      rst_ni       = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      req_valid_i = '0;
      rst_ni      = 1'b1;

      // Single job from requester 0 with the reference vector.
      sc = start_cnt;
      add_job(0, 128'h00112233_44556677_8899aabb_ccddeeff, 2'd0);
      wait_drain("single_drain", 100);
      chk("single_latency", valid_cyc - grant_cyc, 12);
      chk("single_starts", start_cnt - sc, 1);

      // Both requesters busy for four jobs; grant order checked against the model.
      sc = start_cnt;
      gc = n_grants;
      add_job(0, 128'hdeadbeef_00000000_11111111_22222222, 2'd1);
      add_job(1, 128'hcafef00d_33333333_44444444_55555555, 2'd2);
      add_job(0, 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0, 2'd0);
      add_job(1, {$urandom, $urandom, $urandom, $urandom}, 2'd1);
      wait_drain("rr_drain", 200);
      chk("rr_grants", n_grants - gc, 4);
      chk("rr_starts", start_cnt - sc, 4);

      // Engine silent: expect a timeout error 16 WAIT cycles after ISSUE.
      engine_en = 1'b0;
      sc = start_cnt;
      add_job(0, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa, 2'd1);
      wait_drain("timeout_drain", 100);
      chk("timeout_latency", valid_cyc - grant_cyc, TO + 2);
      chk("timeout_starts", start_cnt - sc, 1);
      engine_en = 1'b1;

      // Illegal key select: no engine start, error response the cycle after grant.
      sc = start_cnt;
      add_job(1, 128'h77777777_88888888_99999999_aaaaaaaa, 2'd3);
      wait_drain("illegal_drain", 50);
      chk("illegal_latency", valid_cyc - grant_cyc, 1);
      chk("illegal_starts", start_cnt - sc, 0);

      // Consumer stalls for 20 cycles with a second request queued.
      rsp_ready_i = 1'b0;
      add_job(0, 128'h13579bdf_2468ace0_13579bdf_2468ace0, 2'd2);
      add_job(1, 128'hfedcba98_76543210_fedcba98_76543210, 2'd0);
      sc = 0;
      while (sc < 60 && !rsp_valid_o) begin
         tick();
         sc++;
      end
      chk("stall_rsp_seen", rsp_valid_o, 1'b1);
      snap_data = rsp_data_o;
      snap_ctl  = {rsp_valid_o, rsp_id_o, rsp_err_o};
      gc        = n_grants;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("stall_data", rsp_data_o, snap_data);
         chk("stall_ctl", {rsp_valid_o, rsp_id_o, rsp_err_o}, snap_ctl);
         chk("stall_ready", req_ready_o, '0);
      end
      chk("stall_no_grant", n_grants - gc, 0);
      rsp_ready_i = 1'b1;
      wait_drain("stall_drain", 100);
      chk("regrant_gap", last_gap, 1);

      // Debug mode blocks grants but not a job already running.
      debug_mode_i = 1'b1;
      add_job(0, 128'h0badf00d_0badf00d_0badf00d_0badf00d, 2'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("debug_ready", req_ready_o, '0);
      end
      chk("debug_busy", busy_o, 1'b0);
      debug_mode_i = 1'b0;
      wait_start(10);
      repeat (3) tick();
      debug_mode_i = 1'b1;
      wait_drain("debug_drain", 100);
      debug_mode_i = 1'b0;

      // Reset in the middle of WAIT: outputs drop at once, job is discarded.
      add_job(1, 128'h11112222_33334444_55556666_77778888, 2'd2);
      wait_start(10);
      repeat (4) tick();
      chk("midwait_busy", busy_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      repeat (8) tick();
      rst_ni = 1'b1;

      // Recovery after reset: pointer back at 0, normal job completes.
      add_job(0, 128'h99990000_99990000_99990000_99990000, 2'd0);
      wait_drain("recover_drain", 100);
      chk("recover_latency", valid_cyc - grant_cyc, 12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
Shares one AES-192 engine between N_REQ requesters (e.g. core-side MMIO port and DMA) using round-robin arbitration. Each request holds a 128-bit block and a 2-bit key select. The block drives the engine's start, data and key-select inputs, waits for the engine's valid, and returns the 128-bit result tagged with the requester ID. It sits between the requesters and the AES engine, in place of direct register-driven start.

Parameters:
N_REQ, 2, number of requesters (2..8)
ID_W, $clog2(N_REQ) (min 1), width of the requester ID
TIMEOUT, 64, max cycles to wait for engine valid before aborting (>=16)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
debug_mode_i  in  1  high = grant nothing new
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept (one-hot or zero)
req_data_i  in  N_REQ*128  per-requester input block
req_ksel_i  in  N_REQ*2  per-requester key select
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result accept
rsp_data_o  out  128  result block (zero on error)
rsp_id_o  out  ID_W  requester index of result
rsp_err_o  out  1  timeout or illegal key_sel
aes_start_o  out  1  one-cycle start pulse to engine
aes_data_o  out  128  engine input block (registered)
aes_ksel_o  out  2  engine key select (registered)
aes_out_i  in  128  engine result
aes_out_valid_i  in  1  engine result valid
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE, rr pointer=0, all outputs 0, timeout counter 0. Reset mid-operation discards the job. The engine is not reset by this block.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if !debug_mode_i and any req_valid_i, grant the first valid index at or after the rr pointer (wrapping). Same cycle: req_ready_o[g]=1 (combinational, one-hot). Latch data, ksel and id. Advance rr pointer to g+1 mod N_REQ. Go to ISSUE. With debug_mode_i=1, req_ready_o=0 and stay in IDLE.
- Illegal ksel (2'b11) at grant: skip the engine. Go straight to RESP with rsp_err_o=1 and rsp_data_o=0.
- ISSUE: aes_start_o=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT: ignore aes_out_valid_i on the first WAIT cycle, because a stale valid from the previous job may still be high. From the second cycle on, valid=1 captures aes_out_i into rsp_data_o with err=0 and goes to RESP. The counter increments each WAIT cycle. When count reaches TIMEOUT-1 without valid, go to RESP with err=1 and data=0.
- RESP: rsp_valid_o=1 and rsp_data_o, rsp_id_o, rsp_err_o held stable until rsp_ready_i. The handshake cycle returns to IDLE. The earliest next grant is the cycle after that, so req_ready_o=0 in RESP.
- aes_data_o and aes_ksel_o hold their last job's values until the next grant. They are zeroed on reset.
- debug_mode_i rising during ISSUE/WAIT/RESP: the current job completes normally. Only new grants are blocked.
- Latency, grant to rsp_valid_o: 1 (ISSUE) + engine latency + 1 (capture) cycles.
- Outputs are registered except req_ready_o.

Decomposition:
- Shared package aes_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}; KSEL_ILLEGAL = 2'b11; default TIMEOUT.
- One sub-module, rr_arbiter (N_REQ-wide round-robin priority pick with pointer update enable). It is reusable by other peripheral arbiters.

Test Plan:
- Single requester 0: data=128'h00112233_44556677_8899aabb_ccddeeff, ksel=0. Engine model returns the input XOR 1 after 10 cycles. Expect one start pulse, rsp_data = input^1, id=0, err=0, grant-to-valid = 12 cycles.
- Both requesters valid continuously for 4 jobs → grants alternate 0,1,0,1. rsp_id follows the same order. No job is lost or duplicated.
- Engine never asserts valid, TIMEOUT=16 → rsp_valid with err=1 and data=0 exactly 16 WAIT cycles after ISSUE. FSM then returns to IDLE.
- ksel=2'b11 → no aes_start_o pulse. rsp_err=1 on the cycle after the grant.
- rsp_ready_i held low 20 cycles → rsp fields stable, no new grant. Raise ready → IDLE, then next grant the following cycle.
- debug_mode_i=1 with req_valid pending → req_ready stays 0. Asserting debug mid-WAIT lets the job finish. Reset asserted mid-WAIT → all outputs 0 immediately.
